// File: rtl/note_detect.sv
// Measures the high-phase width of a square-wave tone in tick units and scans
// the frequency table (bank 0 then bank 1) for the first entry within TOL.
module note_detect #(
  parameter int TOL       = 1,
  parameter int MIN_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       audio_in,
  output logic [3:0] db_address,
  output logic       db_is_highkey,
  input  logic [7:0] db_entry,
  output logic       note_valid,
  output logic       note_hit,
  output logic [3:0] note_addr,
  output logic       note_highkey,
  output logic [7:0] note_count
);

  typedef enum logic [1:0] {IDLE, MEASURE, SCAN, DONE} state_t;

  localparam logic [3:0] LAST_ADDR = 4'd12;

  state_t     state_reg, state_next;
  logic       sync1_reg, sync2_reg, prev_reg;
  logic [7:0] count_reg, count_next;
  logic [3:0] addr_reg, addr_next;
  logic       bank_reg, bank_next;
  logic       hit_reg, hit_next;
  logic [3:0] naddr_reg, naddr_next;
  logic       nbank_reg, nbank_next;
  logic [7:0] ncount_reg, ncount_next;

  logic       rise;
  logic [8:0] count9, entry9, diff;
  logic       is_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= audio_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

  // Unsigned 9-bit absolute difference so the comparison never wraps.
  assign count9   = {1'b0, count_reg};
  assign entry9   = {1'b0, db_entry};
  assign diff     = (count9 >= entry9) ? (count9 - entry9) : (entry9 - count9);
  assign is_match = (diff <= 9'(TOL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= 8'd0;
      addr_reg   <= 4'd0;
      bank_reg   <= 1'b0;
      hit_reg    <= 1'b0;
      naddr_reg  <= 4'd0;
      nbank_reg  <= 1'b0;
      ncount_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      addr_reg   <= addr_next;
      bank_reg   <= bank_next;
      hit_reg    <= hit_next;
      naddr_reg  <= naddr_next;
      nbank_reg  <= nbank_next;
      ncount_reg <= ncount_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    addr_next   = 4'd0;
    bank_next   = 1'b0;
    hit_next    = hit_reg;
    naddr_next  = naddr_reg;
    nbank_next  = nbank_reg;
    ncount_next = ncount_reg;

    case (state_reg)
      IDLE: begin
        // The rise cycle already has sync high, so it contributes its tick here;
        // otherwise the counter stays cleared.
        count_next = (rise && tick_en) ? 8'd1 : 8'd0;
        if (rise) begin
          state_next = MEASURE;
        end
      end

      MEASURE: begin
        if (!sync2_reg) begin
          if (count_reg < 8'(MIN_COUNT)) begin
            hit_next    = 1'b0;
            naddr_next  = 4'd0;
            nbank_next  = 1'b0;
            ncount_next = count_reg;
            state_next  = DONE;
          end else begin
            state_next = SCAN;
          end
        end else if (tick_en && (count_reg != 8'hFF)) begin
          count_next = count_reg + 8'd1;
        end
      end

      SCAN: begin
        if (is_match) begin
          hit_next    = 1'b1;
          naddr_next  = addr_reg;
          nbank_next  = bank_reg;
          ncount_next = count_reg;
          state_next  = DONE;
        end else if (addr_reg == LAST_ADDR) begin
          if (bank_reg) begin
            hit_next    = 1'b0;
            naddr_next  = 4'd0;
            nbank_next  = 1'b0;
            ncount_next = count_reg;
            state_next  = DONE;
          end else begin
            bank_next = 1'b1;
            addr_next = 4'd0;
          end
        end else begin
          bank_next = bank_reg;
          addr_next = addr_reg + 4'd1;
        end
      end

      DONE: begin
        count_next = 8'd0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign db_address    = addr_reg;
  assign db_is_highkey = bank_reg;
  assign note_valid    = (state_reg == DONE) && !rst;
  assign note_hit      = hit_reg;
  assign note_addr     = naddr_reg;
  assign note_highkey  = nbank_reg;
  assign note_count    = ncount_reg;

endmodule

// File: tb/tb_note_detect.sv
// Directed bench for note_detect: a frequency-table stand-in, a first-match
// scan model, and a per-cycle checker of the result outputs.
module tb_note_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b1;
  logic       audio_in = 1'b0;
  logic [3:0] db_address;
  logic       db_is_highkey;
  logic [7:0] db_entry;
  logic       note_valid;
  logic       note_hit;
  logic [3:0] note_addr;
  logic       note_highkey;
  logic [7:0] note_count;

  note_detect #(.TOL(1), .MIN_COUNT(8)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .audio_in(audio_in),
    .db_address(db_address), .db_is_highkey(db_is_highkey), .db_entry(db_entry),
    .note_valid(note_valid), .note_hit(note_hit), .note_addr(note_addr),
    .note_highkey(note_highkey), .note_count(note_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [3:0] addr;
    logic       hk;
    logic [7:0] count;
  } res_t;

  logic [7:0] table_mem [0:31];
  assign db_entry = table_mem[{db_is_highkey, db_address}];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   valid_cnt = 0;
  int   tick_div = 1;
  int   tcnt = 0;
  res_t exp_q[$];
  res_t held = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // First entry (bank 0 then bank 1, addresses 0..12) within 1 tick wins.
  function automatic res_t model(input int ticks);
    res_t r;
    int c, e, d;
    r = '0;
    c = (ticks > 255) ? 255 : ticks;
    r.count = 8'(c);
    if (c < 8) return r;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 13; a++) begin
        e = int'(table_mem[b*16 + a]);
        d = (c > e) ? c - e : e - c;
        if (d <= 1) begin
          r.hit  = 1'b1;
          r.addr = 4'(a);
          r.hk   = b[0];
          return r;
        end
      end
    end
    return r;
  endfunction

  initial begin
    int b0 [13] = '{91, 48, 86, 76, 72, 68, 64, 60, 57, 54, 51, 45, 43};
    int b1 [13] = '{48, 91, 81, 40, 38, 36, 34, 32, 30, 28, 27, 26, 25};
    for (int i = 0; i < 32; i++) table_mem[i] = 8'd0;
    for (int i = 0; i < 13; i++) begin
      table_mem[i]      = 8'(b0[i]);
      table_mem[16 + i] = 8'(b1[i]);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      tcnt++;
      tick_en = (tick_div <= 1) || ((tcnt % tick_div) == 0);
    end
  end

  // Per-cycle checker: results must match the expectation on a strobe and hold otherwise.
  initial begin
    logic rst_s;
    res_t e;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) begin
        exp_q.delete();
        held = '0;
        chk("rst_valid", int'(note_valid), 0);
        chk("rst_result", int'({note_hit, note_addr, note_highkey, note_count}), 0);
        chk("rst_db", int'({db_is_highkey, db_address}), 0);
      end else if (note_valid) begin
        valid_cnt++;
        chk("pending_expect", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("hit", int'(note_hit), int'(e.hit));
          chk("addr", int'(note_addr), int'(e.addr));
          chk("highkey", int'(note_highkey), int'(e.hk));
          chk("count", int'(note_count), int'(e.count));
          held = e;
        end
        chk("done_db_idle", int'({db_is_highkey, db_address}), 0);
      end else begin
        chk("hold_result", int'({note_hit, note_addr, note_highkey, note_count}), int'(held));
        chk("db_addr_range", int'(db_address <= 4'd12), 1);
      end
    end
  end

  task automatic run_pulse(input int width, input int div, input int max_lat);
    res_t e;
    int   base, lat;
    bit   got;
    tick_div = div;
    e = model(width / div);
    exp_q.push_back(e);
    base = valid_cnt;
    @(negedge clk) audio_in = 1'b1;
    repeat (width) @(negedge clk);
    audio_in = 1'b0;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 60) begin
      @(posedge clk);
      #2;
      lat++;
      if (valid_cnt != base) got = 1'b1;
    end
    chk($sformatf("valid_seen_w%0d", width), int'(got), 1);
    if (got) chk($sformatf("latency_w%0d_%0d", width, lat), int'(lat <= max_lat), 1);
    repeat (3) @(negedge clk);
    chk($sformatf("single_valid_w%0d", width), valid_cnt - base, 1);
    tick_div = 1;
  endtask

  initial begin
    res_t r;
    int   base;

    // Hand-computed pins on the model against the table above.
    r = model(86);  chk("model86", int'({r.hit, r.addr, r.hk}), int'({1'b1, 4'd2, 1'b0}));
    r = model(48);  chk("model48", int'({r.hit, r.addr, r.hk}), int'({1'b1, 4'd1, 1'b0}));
    r = model(80);  chk("model80", int'({r.hit, r.addr, r.hk}), int'({1'b1, 4'd2, 1'b1}));
    r = model(88);  chk("model88", int'(r.hit), 0);
    r = model(300); chk("model300", int'(r.count), 255);

    // Reset held while audio toggles.
    repeat (3) begin
      @(negedge clk);
      audio_in = ~audio_in;
    end
    @(negedge clk);
    audio_in = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_no_valid", valid_cnt, 0);

    run_pulse(86, 1, 30);
    run_pulse(48, 1, 30);
    run_pulse(81, 1, 30);
    run_pulse(80, 1, 30);
    run_pulse(87, 1, 30);
    run_pulse(88, 1, 30);
    run_pulse(200, 1, 30);
    run_pulse(300, 1, 30);
    run_pulse(3, 1, 6);
    run_pulse(7, 1, 6);
    run_pulse(8, 1, 30);

    // Reset mid-scan aborts without a strobe.
    base = valid_cnt;
    @(negedge clk) audio_in = 1'b1;
    repeat (200) @(negedge clk);
    audio_in = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_scan_no_valid", valid_cnt - base, 0);

    // A pulse that rises during SCAN is not measured.
    base = valid_cnt;
    exp_q.push_back(model(200));
    @(negedge clk) audio_in = 1'b1;
    repeat (200) @(negedge clk);
    audio_in = 1'b0;
    repeat (2) @(negedge clk);
    audio_in = 1'b1;
    repeat (86) @(negedge clk);
    audio_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignored_pulse", valid_cnt - base, 1);
    run_pulse(86, 1, 30);

    // Half-rate time base.
    run_pulse(172, 2, 30);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/note_detect.md
Name: note_detect

Overview:
- Inverse of the note-frequency lookup: measures the high-phase width of an incoming square-wave tone and resolves it back to a note address and key bank.
- Drives the frequency table's address/bank inputs itself and reads the returned 8-bit half-period entry each cycle.
- Sits between an external/loopback audio input and the debug/score-check logic; its output is a one-cycle result strobe per measured pulse.

Parameters:
- TOL, 1, maximum |count − entry| accepted as a match (ticks).
- MIN_COUNT, 8, measured widths below this are reported as no-hit without scanning.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- tick_en  input  1  measurement time-base strobe; one tick = one table unit
- audio_in  input  1  asynchronous square-wave tone input
- db_address  output  4  address driven to the frequency table
- db_is_highkey  output  1  bank select driven to the frequency table
- db_entry  input  8  combinational table return for the current db_address/db_is_highkey
- note_valid  output  1  one-cycle result strobe
- note_hit  output  1  1 = table match found
- note_addr  output  4  matched address (0 when no hit)
- note_highkey  output  1  matched bank (0 when no hit)
- note_count  output  8  measured width in ticks

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset forces all outputs, the counter and the sync flops to 0, and the state to IDLE.
- audio_in passes through a 2-flop synchronizer followed by a previous-value register; rise/fall detection uses the synchronized signal.
- FSM states: IDLE, MEASURE, SCAN, DONE.
- IDLE:
  - Counter cleared.
  - A synchronized rising edge moves the FSM to MEASURE.
- MEASURE:
  - On each cycle with sync=1 and tick_en=1, the 8-bit counter increments, saturating at 255.
  - A synchronized falling edge (sync=0) leaves MEASURE.
  - If count < MIN_COUNT, go to DONE with hit=0.
  - Otherwise go to SCAN with db_address=0 and db_is_highkey=0.
- SCAN:
  - One table entry is compared per clock.
  - Scan order: bank 0, addresses 0..12, then bank 1, addresses 0..12. Address 13 (rest) is never scanned.
  - Match test: |count − db_entry| <= TOL, evaluated as 9-bit unsigned difference arithmetic with no wrap.
  - The first match wins: latch address and bank, set hit=1, go to DONE.
  - After bank 1 address 12 with no match: hit=0, go to DONE.
  - Worst-case SCAN length is 26 cycles.
- DONE:
  - note_valid=1 for exactly one cycle, with note_hit/note_addr/note_highkey/note_count valid in that same cycle.
  - The FSM then returns to IDLE.
  - Result outputs hold their values until the next DONE; only note_valid is a pulse.
- db_address and db_is_highkey return to 0 outside SCAN.
- Edges arriving during SCAN/DONE are ignored. A pulse whose rising edge occurs in SCAN/DONE is not measured; measurement restarts at the next rising edge seen in IDLE.
- With tick_en tied high, note_count equals the audio_in high width in clocks (both edges are delayed equally by the synchronizer).
- Counter saturation at 255: the measurement still completes on the falling edge; the scan then returns hit=0 because the maximum table entry is 91.
- Reset asserted in any state (including mid-SCAN) aborts the operation in the same cycle with no note_valid pulse.
- Latency: note_valid asserts no later than falling edge + 2 (sync) + 1 + 26 + 1 clocks.

Test Plan:
- Reset: hold rst 3 cycles while audio_in toggles -> all outputs 0, no note_valid, db_address=0.
- tick_en=1, audio_in high for 86 clocks -> note_valid once; hit=1, addr=2, highkey=0, count=86.
- High width 48 (matches bank0 addr1 and bank1 addr0) -> hit=1, addr=1, highkey=0 (first-match order).
- High width 81 -> hit=1, addr=2, highkey=1, count=81. High width 80 with TOL=1 -> same result.
- Width 200 -> hit=0, addr=0, count=200. Width 300 -> count=255, hit=0. Width 3 -> hit=0, count=3, note_valid within 4 clocks of the synchronized fall (no scan).
- Assert rst mid-SCAN -> no note_valid. A second 86-clock pulse begun in SCAN is ignored; the next pulse after IDLE gives addr=2, highkey=0. With tick_en every 2nd clock, a 172-clock pulse gives count=86.
